// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: funct3 encodings, FSM states,
// and the byte-lane helpers used for stores and load extraction.
package mau_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mau_state_e;

   // Unlisted encodings fall through to word handling in every helper.
   function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B, F3_BU: return 4'b0001 << off;
         F3_H, F3_HU: return 4'b0011 << {off[1], 1'b0};
         default:     return 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return off[0];
         default:     return |off;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         F3_B:    return 32'($signed(sh[7:0]));
         F3_H:    return 32'($signed(sh[15:0]));
         F3_BU:   return {24'd0, sh[7:0]};
         F3_HU:   return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane steering: store enables/data shift toward memory,
// load data extraction and extension back toward writeback.
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [2:0]  st_f3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [2:0]  ld_f3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] rdata_ext
);

   assign be        = be_gen(st_f3, st_off);
   assign wdata     = st_data << {st_off, 3'b000};
   assign rdata_ext = load_ext(ld_f3, ld_off, rdata);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: req/ack handshake with data memory, timeout abort.
// Build option MAU_STORE_BUFFER_EN: stores are posted into a one-entry buffer.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [31:0]       ALUResult,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   output logic              LoadValid,
   output logic              Stall,
   output logic              MisalignErr,
   output logic              BusErr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   mau_state_e  state, state_nxt;
   logic [7:0]  cnt;
   logic        posted_p1, ld_p1;
   logic [2:0]  f3_p1;
   logic [1:0]  off_p1;
   logic [3:0]  be_w;
   logic [31:0] wdata_w, rdata_ext;
   logic        req_any, bad, hold_off, accept, reject, timeout, post_st;

`ifdef MAU_STORE_BUFFER_EN
   assign post_st = MemWrite;
`else
   assign post_st = 1'b0;
`endif

   assign req_any  = MemRead | MemWrite;
   assign bad      = misaligned(funct3, ALUResult[1:0]);
   // The instruction whose transaction just timed out is still on the inputs; let it retire.
   assign hold_off = BusErr & ~posted_p1;
   assign accept   = (state == IDLE) & req_any & ~bad & ~hold_off;
   assign reject   = (state == IDLE) & req_any &  bad & ~hold_off;
   assign timeout  = (state == REQ) & ~mem_ack & (cnt == 8'(TIMEOUT_CYC - 1));

   mau_lane_align u_align (
      .st_f3     (funct3),
      .st_off    (ALUResult[1:0]),
      .st_data   (WriteData),
      .be        (be_w),
      .wdata     (wdata_w),
      .ld_f3     (f3_p1),
      .ld_off    (off_p1),
      .rdata     (mem_rdata),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = REQ;
         REQ:     if (mem_ack) state_nxt = DONE;
                  else if (timeout) state_nxt = IDLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A posted store only holds the pipeline when another access is waiting behind it.
   always_comb begin
      Stall = 1'b0;
      case (state)
         IDLE:    Stall = accept & ~post_st;
         REQ:     Stall = posted_p1 ? req_any : 1'b1;
         DONE:    Stall = posted_p1 ? req_any : 1'b0;
         default: Stall = 1'b0;
      endcase
   end

   // ---- stage p1: transaction issue / completion ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= '0;
         mem_wdata   <= '0;
         ReadData    <= '0;
         LoadValid   <= 1'b0;
         MisalignErr <= 1'b0;
         BusErr      <= 1'b0;
         cnt         <= '0;
         posted_p1   <= 1'b0;
         ld_p1       <= 1'b0;
      end else begin
         LoadValid   <= 1'b0;
         MisalignErr <= 1'b0;
         BusErr      <= 1'b0;
         if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {ALUResult[ADDR_W-1:2], 2'b00};
            mem_be    <= be_w;
            mem_wdata <= wdata_w;
            cnt       <= '0;
            posted_p1 <= post_st;
            ld_p1     <= ~MemWrite;
         end
         if (reject) begin
            MisalignErr <= 1'b1;
            ReadData    <= '0;
         end
         if (state == REQ) begin
            if (mem_ack) begin
               mem_req <= 1'b0;
               if (ld_p1) begin
                  LoadValid <= 1'b1;
                  ReadData  <= rdata_ext;
               end
            end else if (timeout) begin
               mem_req <= 1'b0;
               BusErr  <= 1'b1;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         f3_p1  <= funct3;
         off_p1 <= ALUResult[1:0];
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests/results queued at issue,
// popped as the memory interface and result pulses appear.
module tb_mem_access_unit;

   localparam int TO = 16;
`ifdef MAU_STORE_BUFFER_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   typedef enum int {K_LOAD = 0, K_STORE = 1, K_MIS = 2, K_BUS = 3} kind_e;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;
   typedef struct {
      kind_e       kind;
      logic [31:0] data;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] ALUResult = '0, WriteData = '0;
   logic [31:0] ReadData;
   logic        LoadValid, Stall, MisalignErr, BusErr;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .LoadValid(LoadValid), .Stall(Stall),
      .MisalignErr(MisalignErr), .BusErr(BusErr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   req_t req_q[$];
   res_t res_q[$];

   // memory model: ack after ack_delay cycles of mem_req, or never when ack_en=0
   int          ack_delay = 0;
   bit          ack_en = 1'b1;
   logic [31:0] rdata_val = '0;
   int          wcnt = 0;
   always @(negedge clk) begin
      if (mem_ack) begin
         mem_ack <= 1'b0;
         wcnt    <= 0;
      end else if (mem_req) begin
         if (ack_en && wcnt == ack_delay) begin
            mem_ack   <= 1'b1;
            mem_rdata <= rdata_val;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   logic prev_req = 1'b0;
   int   rise_cyc = 0;
   always @(negedge clk) begin : mon
      automatic req_t rq;
      automatic res_t rs;
      if (rst_n) begin
         if (mem_req && !prev_req) begin
            rise_cyc <= cyc;
            if (req_q.size() == 0) chk("unexpected_req", 1, 0);
            else begin
               rq = req_q.pop_front();
               chk("mem_we", {31'd0, mem_we}, {31'd0, rq.we});
               chk("mem_addr", mem_addr, rq.addr);
               chk("mem_be", {28'd0, mem_be}, {28'd0, rq.be});
               if (rq.we) chk("mem_wdata", mem_wdata, rq.wdata);
            end
         end
         if (LoadValid || MisalignErr || BusErr) begin
            if (res_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               rs = res_q.pop_front();
               if (LoadValid) begin
                  chk("load_kind", K_LOAD, rs.kind);
                  chk("ReadData", ReadData, rs.data);
                  chk("stall_in_done", {31'd0, Stall}, 0);
               end
               if (MisalignErr) begin
                  chk("mis_kind", K_MIS, rs.kind);
                  chk("mis_ReadData", ReadData, 0);
                  chk("mis_mem_req", {31'd0, mem_req}, 0);
               end
               if (BusErr) begin
                  chk("bus_kind", K_BUS, rs.kind);
                  chk("buserr_delay", 32'(cyc - rise_cyc), TO);
               end
            end
         end
      end
      prev_req <= mem_req;
   end

   task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input kind_e k,
                        input logic [3:0] ebe, input logic [31:0] edata, output int stalls);
      req_t rq;
      res_t rs;
      if (k != K_MIS) begin
         rq.we    = wr;
         rq.addr  = {addr[31:2], 2'b00};
         rq.be    = ebe;
         rq.wdata = edata;
         req_q.push_back(rq);
      end
      if (k != K_STORE) begin
         rs.kind = k;
         rs.data = (k == K_LOAD) ? edata : 32'd0;
         res_q.push_back(rs);
      end
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
      stalls = 0;
      @(negedge clk);
      while (Stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (Stall) chk("stall_bound", 1, 0);
      @(posedge clk);
      #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   s;
      req_t rq;
      #12;
      chk("rst_mem_req", {31'd0, mem_req}, 0);
      chk("rst_stall", {31'd0, Stall}, 0);
      chk("rst_loadvalid", {31'd0, LoadValid}, 0);
      chk("rst_readdata", ReadData, 0);
      chk("rst_mem_be", {28'd0, mem_be}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_errs", {30'd0, BusErr, MisalignErr}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      ack_delay = 2;
      issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, K_STORE, 4'b1111, 32'hDEADBEEF, s);
      chk("sw_stalls", s, BUF ? 0 : 4);
      idle(8);
      ack_delay = 0;
      issue(0, 1, 3'b000, 32'h103, 32'h000000AB, K_STORE, 4'b1000, 32'hAB000000, s);
      chk("sb_stalls", s, BUF ? 0 : 2);
      idle(4);

      ack_delay = 1; rdata_val = 32'h0000F0FF;
      issue(1, 0, 3'b001, 32'h200, 0, K_LOAD, 4'b0011, 32'hFFFFF0FF, s);
      chk("lh_stalls", s, 3);
      issue(1, 0, 3'b101, 32'h200, 0, K_LOAD, 4'b0011, 32'h0000F0FF, s);
      rdata_val = 32'hF0FF0000;
      issue(1, 0, 3'b001, 32'h202, 0, K_LOAD, 4'b1100, 32'hFFFFF0FF, s);
      issue(1, 0, 3'b101, 32'h202, 0, K_LOAD, 4'b1100, 32'h0000F0FF, s);
      rdata_val = 32'h00008000;
      issue(1, 0, 3'b000, 32'h201, 0, K_LOAD, 4'b0010, 32'hFFFFFF80, s);
      issue(1, 0, 3'b100, 32'h201, 0, K_LOAD, 4'b0010, 32'h00000080, s);
      rdata_val = 32'h7F000000;
      issue(1, 0, 3'b000, 32'h203, 0, K_LOAD, 4'b1000, 32'h0000007F, s);

      ack_delay = 0; rdata_val = 32'h12345678;
      issue(1, 0, 3'b010, 32'h300, 0, K_LOAD, 4'b1111, 32'h12345678, s);
      chk("lw_zero_wait_stalls", s, 2);
      issue(1, 0, 3'b011, 32'h304, 0, K_LOAD, 4'b1111, 32'h12345678, s);
      issue(1, 0, 3'b110, 32'h308, 0, K_LOAD, 4'b1111, 32'h12345678, s);

      issue(1, 0, 3'b010, 32'h101, 0, K_MIS, 4'b0000, 32'h0, s);
      chk("mis_lw_stalls", s, 0);
      issue(1, 0, 3'b001, 32'h103, 0, K_MIS, 4'b0000, 32'h0, s);
      chk("mis_lh_stalls", s, 0);

      issue(1, 1, 3'b010, 32'h400, 32'h55AA55AA, K_STORE, 4'b1111, 32'h55AA55AA, s);
      chk("rw_store_stalls", s, BUF ? 0 : 2);
      idle(4);

      ack_en = 1'b0;
      issue(1, 0, 3'b010, 32'h500, 0, K_BUS, 4'b1111, 32'h0, s);
      chk("timeout_stalls", s, TO + 1);
      ack_en = 1'b1;
      idle(2);

      ack_en = 1'b0;
      rq.we = 1'b0; rq.addr = 32'h600; rq.be = 4'b1111; rq.wdata = '0;
      req_q.push_back(rq);
      MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h600;
      repeat (4) @(posedge clk);
      #2;
      MemRead = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", {31'd0, mem_req}, 0);
      chk("async_rst_stall", {31'd0, Stall}, 0);
      chk("async_rst_mem_be", {28'd0, mem_be}, 0);
      @(negedge clk) rst_n = 1'b1;
      ack_en = 1'b1;
      @(posedge clk);
      #1;
      ack_delay = 0; rdata_val = 32'hCAFEF00D;
      issue(1, 0, 3'b010, 32'h604, 0, K_LOAD, 4'b1111, 32'hCAFEF00D, s);
      chk("post_rst_lw_stalls", s, 2);

`ifdef MAU_STORE_BUFFER_EN
      ack_delay = 1; rdata_val = 32'h0BADF00D;
      issue(0, 1, 3'b010, 32'h700, 32'h11223344, K_STORE, 4'b1111, 32'h11223344, s);
      chk("posted_sw_stalls", s, 0);
      issue(1, 0, 3'b010, 32'h704, 0, K_LOAD, 4'b1111, 32'h0BADF00D, s);
      chk("lw_behind_sw_stalls", s, 6);
`endif

      idle(6);
      chk("req_q_empty", req_q.size(), 0);
      chk("res_q_empty", res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
